// File: rtl/clk_x8_seq.sv
// clk_x8_seq: power-up and recovery sequencer for the x8 clock generator.
// Resets the generator, waits for lock, qualifies it, restarts on loss.
module clk_x8_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [2:0] state
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ?
                          RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC   = (MAX_AB > STABLE_CYCLES) ?
                          MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic [1:0]    sync_q, sync_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          locked_s;

  assign locked_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous lock flag
  always_comb begin
    sync_d = {sync_q[0], locked};
  end

  // Next state, counters, and outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RST;
          retry_d = '0;
        end
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == MAX_R) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_PLL_RST;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == ST_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_PLL_RST;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    pll_rst_d = (state_d == S_IDLE) || (state_d == S_PLL_RST) ||
                (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
  assign state         = state_q;

endmodule
